// File: rtl/word_stream_checker.sv
// Receive-side word stream checker: compares each accepted word with the
// shared expected-sequence function and reports counts, first error and pass.
package wsc_pkg;

  function automatic logic [63:0] exp_word(
    input logic [63:0] idx,
    input logic [63:0] base,
    input logic [63:0] step
  );
    return base + idx * step;
  endfunction

endpackage

module word_stream_checker #(
  parameter int          WIDTH     = 32,
  parameter int          NUM_WORDS = 8,
  parameter int unsigned BASE      = 5,
  parameter int unsigned STEP      = 1,
  localparam int         CW        = $clog2(NUM_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    match_count,
  output logic [CW-1:0]    mismatch_count,
  output logic [CW-1:0]    first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);
  import wsc_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    idx_q;
  logic [CW-1:0]    match_q;
  logic [CW-1:0]    mism_q;
  logic [CW-1:0]    ferr_idx_q;
  logic [WIDTH-1:0] ferr_data_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] exp_d;
  logic             hit_d;
  logic             last_d;

  assign exp_d  = WIDTH'(exp_word(64'(idx_q), 64'(BASE), 64'(STEP)));
  assign hit_d  = (in_data == exp_d);
  assign last_d = (idx_q == CW'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      match_q     <= '0;
      mism_q      <= '0;
      ferr_idx_q  <= '0;
      ferr_data_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_RUN;
            idx_q       <= '0;
            match_q     <= '0;
            mism_q      <= '0;
            ferr_idx_q  <= '0;
            ferr_data_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            idx_q <= idx_q + CW'(1);
            if (hit_d) begin
              match_q <= match_q + CW'(1);
            end else begin
              mism_q <= mism_q + CW'(1);
              // only the first mismatch of a run is captured
              if (mism_q == '0) begin
                ferr_idx_q  <= idx_q;
                ferr_data_q <= in_data;
              end
            end
            if (last_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= hit_d && (mism_q == '0);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign match_count    = match_q;
  assign mismatch_count = mism_q;
  assign first_err_idx  = ferr_idx_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_word_stream_checker.sv
// Randomised bench for word_stream_checker: two instances (default and a
// wrap-around configuration) checked every cycle against a run-history model.
module tb_word_stream_checker;

  logic clk;
  logic rst_n;

  logic        st [2];
  logic        vl [2];
  logic [31:0] dt [2];

  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic        ps  [2];
  logic [3:0]  mc  [2];
  logic [3:0]  xc  [2];
  logic [3:0]  fi  [2];
  logic [31:0] fd  [2];

  logic [3:0] mc0, xc0, fi0;
  logic [2:0] mc1, xc1, fi1;

  int errors = 0;
  int checks = 0;

  word_stream_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .in_valid(vl[0]), .in_data(dt[0]),
    .in_ready(rdy[0]), .busy(bsy[0]),
    .done(dn[0]), .pass(ps[0]),
    .match_count(mc0), .mismatch_count(xc0),
    .first_err_idx(fi0), .first_err_data(fd[0])
  );

  word_stream_checker #(
    .NUM_WORDS(4), .BASE(32'hFFFF_FFFE), .STEP(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .in_valid(vl[1]), .in_data(dt[1]),
    .in_ready(rdy[1]), .busy(bsy[1]),
    .done(dn[1]), .pass(ps[1]),
    .match_count(mc1), .mismatch_count(xc1),
    .first_err_idx(fi1), .first_err_data(fd[1])
  );

  assign mc[0] = mc0;
  assign xc[0] = xc0;
  assign fi[0] = fi0;
  assign mc[1] = {1'b0, mc1};
  assign xc[1] = {1'b0, xc1};
  assign fi[1] = {1'b0, fi1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a run is "active" after start; it records the accepted words.
  int          mn   [2] = '{8, 4};
  logic [31:0] mb   [2] = '{32'd5, 32'hFFFF_FFFE};
  bit          act  [2] = '{0, 0};
  int          wn   [2] = '{0, 0};
  logic [31:0] wd   [2][8];

  function automatic logic [31:0] expw(int s, int i);
    logic [63:0] v;
    v = 64'(mb[s]) + 64'(i);
    return v[31:0];
  endfunction

  function automatic bit running(int s);
    return act[s] && (wn[s] < mn[s]);
  endfunction

  always @(negedge rst_n) begin
    for (int s = 0; s < 2; s++) begin
      act[s] = 0;
      wn[s]  = 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (running(s)) begin
          if (vl[s]) begin
            wd[s][wn[s]] = dt[s];
            wn[s]++;
          end
        end else if (st[s]) begin
          act[s] = 1;
          wn[s]  = 0;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cmp_model(int s);
    int m, x, f;
    logic [31:0] fdat;
    bit d;
    m = 0; x = 0; f = 0; fdat = 0;
    for (int i = 0; i < wn[s]; i++) begin
      if (wd[s][i] == expw(s, i)) m++;
      else begin
        if (x == 0) begin
          f    = i;
          fdat = wd[s][i];
        end
        x++;
      end
    end
    d = act[s] && (wn[s] == mn[s]);
    chk($sformatf("in_ready%0d", s), 32'(rdy[s]), 32'(running(s)));
    chk($sformatf("busy%0d", s), 32'(bsy[s]), 32'(running(s)));
    chk($sformatf("done%0d", s), 32'(dn[s]), 32'(d));
    chk($sformatf("pass%0d", s), 32'(ps[s]), 32'(d && x == 0));
    chk($sformatf("match%0d", s), 32'(mc[s]), 32'(m));
    chk($sformatf("mism%0d", s), 32'(xc[s]), 32'(x));
    chk($sformatf("ferr_idx%0d", s), 32'(fi[s]), 32'(f));
    chk($sformatf("ferr_data%0d", s), fd[s], fdat);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) cmp_model(s);
  end

  int busy_cyc = 0;
  bit count_busy = 0;
  always @(negedge clk) if (count_busy && bsy[0]) busy_cyc++;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(int s);
    st[s] = 1'b1;
    step();
    st[s] = 1'b0;
  endtask

  task automatic send(int s, logic [31:0] d, int gap);
    for (int g = 0; g < gap; g++) begin
      vl[s] = 1'b0;
      step();
    end
    vl[s] = 1'b1;
    dt[s] = d;
    step();
  endtask

  task automatic rand_run(int s);
    do_start(s);
    for (int i = 0; i < mn[s]; i++) begin
      if ($urandom_range(0, 3) == 0) send(s, $urandom, $urandom_range(0, 2));
      else send(s, expw(s, i), $urandom_range(0, 2));
    end
    vl[s] = 1'b0;
    step();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      st[s] = 0; vl[s] = 0; dt[s] = 0;
    end
    rst_n = 1'b0;
    step();
    step();
    chk("reset_in_ready", 32'(rdy[0]), 32'd0);
    chk("reset_match", 32'(mc[0]), 32'd0);
    rst_n = 1'b1;
    step();

    // clean back-to-back run
    count_busy = 1;
    do_start(0);
    for (int i = 0; i < 8; i++) send(0, 32'(5 + i), 0);
    vl[0] = 1'b0;
    step();
    count_busy = 0;
    chk("t1_done", 32'(dn[0]), 32'd1);
    chk("t1_pass", 32'(ps[0]), 32'd1);
    chk("t1_match", 32'(mc[0]), 32'd8);
    chk("t1_busy_cycles", 32'(busy_cyc), 32'd8);

    // errors with gaps, start pulses mid-run
    do_start(0);
    for (int i = 0; i < 8; i++) begin
      st[0] = (i == 4);
      if (i == 3) send(0, 32'hDEAD_BEEF, $urandom_range(0, 3));
      else if (i == 6) send(0, 32'h0, $urandom_range(0, 3));
      else send(0, 32'(5 + i), $urandom_range(0, 3));
    end
    st[0] = 1'b0;
    vl[0] = 1'b0;
    step();
    chk("t2_mism", 32'(xc[0]), 32'd2);
    chk("t2_match", 32'(mc[0]), 32'd6);
    chk("t2_ferr_idx", 32'(fi[0]), 32'd3);
    chk("t2_ferr_data", fd[0], 32'hDEAD_BEEF);
    chk("t2_pass", 32'(ps[0]), 32'd0);

    // valid while DONE, then start+valid together
    vl[0] = 1'b1;
    dt[0] = 32'd5;
    step();
    step();
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    vl[0] = 1'b0;
    chk("t6_busy", 32'(bsy[0]), 32'd1);
    chk("t6_done", 32'(dn[0]), 32'd0);
    chk("t6_match", 32'(mc[0]), 32'd0);
    chk("t6_ferr_data", fd[0], 32'd0);
    for (int i = 0; i < 8; i++) send(0, 32'(5 + i), 0);
    vl[0] = 1'b0;
    step();

    // wrap-around instance
    do_start(1);
    send(1, 32'hFFFF_FFFE, 0);
    send(1, 32'hFFFF_FFFF, 1);
    send(1, 32'h0, 0);
    send(1, 32'h1, 0);
    vl[1] = 1'b0;
    step();
    chk("t3_pass", 32'(ps[1]), 32'd1);
    chk("t3_match", 32'(mc[1]), 32'd4);

    // asynchronous reset mid-run
    do_start(0);
    for (int i = 0; i < 3; i++) send(0, 32'(5 + i), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(bsy[0]), 32'd0);
    chk("t4_match", 32'(mc[0]), 32'd0);
    chk("t4_in_ready", 32'(rdy[0]), 32'd0);
    vl[0] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t4_idle_ready", 32'(rdy[0]), 32'd0);
    do_start(0);
    for (int i = 0; i < 8; i++) send(0, 32'(5 + i), 0);
    vl[0] = 1'b0;
    step();
    chk("t4_rerun_match", 32'(mc[0]), 32'd8);

    for (int r = 0; r < 20; r++) rand_run(r % 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
